sc_chain_loader: RTL and testbench

Configuration loader for the scan chain of set/reset D flip-flops that holds the fabric's configuration bits. It accepts bitstream words over a valid/ready handshake, serializes them LSB-first into the chain head under a per-cycle shift enable, and counts exactly CHAIN_LEN shifts. It then runs a recirculating readback pass that checks chain parity without disturbing the loaded contents. It sits between the bitstream source (JTAG/SPI front end) and the configuration chain.

---
 rtl/sc_chain_loader.sv | 146 ++++++++++++++
 tb/tb_sc_chain_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_chain_loader.sv
// sc_chain_loader
// Loads the configuration scan chain from a word-wide bitstream, then runs a
// recirculating readback pass that compares chain parity against the parity
// of the bits that were shifted in.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   start_i         one-cycle load request, sampled only in IDLE
//   din_i           bitstream word, bit 0 shifted first
//   din_valid_i     din_i holds a valid word
//   din_ready_o     loader accepts din_i this cycle
//   sc_d_o          serial data to the chain head
//   sc_en_o         chain shifts on the edge that ends this cycle
//   sc_clr_o        synchronous clear request to the chain
//   sc_q_i          registered Q of the chain tail flop
//   busy_o          loader is not idle
//   done_o          one-cycle pulse when load and verify complete
//   err_o           parity mismatch of the last completed load
module sc_chain_loader #(
  parameter  int CHAIN_LEN = 64,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1),
  localparam int WC_W      = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [WORD_W-1:0] din_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  output logic              sc_d_o,
  output logic              sc_en_o,
  output logic              sc_clr_o,
  input  logic              sc_q_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, SHIFT, VERIFY, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              par_in_q, par_in_d;
  logic              par_out_q, par_out_d;
  logic              err_q, err_d;
  logic              din_ready_q, sc_en_q, sc_clr_q, busy_q, done_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    par_in_d   = par_in_q;
    par_out_d  = par_out_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d   = CLEAR;
        err_d     = 1'b0;
        bit_cnt_d = '0;
        par_in_d  = 1'b0;
        par_out_d = 1'b0;
      end
      CLEAR: state_d = FETCH;
      FETCH: if (din_valid_i) begin
        shreg_d    = din_i;
        word_cnt_d = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        shreg_d    = shreg_q >> 1;
        par_in_d   = par_in_q ^ shreg_q[0];
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        word_cnt_d = word_cnt_q + WC_W'(1);
        // Chain full wins over word end: leftover bits of the last word are dropped.
        if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
          state_d   = VERIFY;
          bit_cnt_d = '0;
        end else if (word_cnt_d == WC_W'(WORD_W)) begin
          state_d = FETCH;
        end
      end
      VERIFY: begin
        par_out_d = par_out_q ^ sc_q_i;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
          state_d = DONE;
          // Include the final tail bit so err is valid together with done.
          err_d   = par_in_q ^ par_out_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      par_in_q    <= 1'b0;
      par_out_q   <= 1'b0;
      err_q       <= 1'b0;
      din_ready_q <= 1'b0;
      sc_en_q     <= 1'b0;
      sc_clr_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      par_in_q    <= par_in_d;
      par_out_q   <= par_out_d;
      err_q       <= err_d;
      din_ready_q <= (state_d == FETCH);
      sc_en_q     <= (state_d == SHIFT) || (state_d == VERIFY);
      sc_clr_q    <= (state_d == CLEAR);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  // During VERIFY the tail is fed straight back to the head so the pass is
  // non-destructive; this path must stay combinational to keep bit alignment.
  always_comb begin
    sc_d_o = 1'b0;
    if (state_q == SHIFT)       sc_d_o = shreg_q[0];
    else if (state_q == VERIFY) sc_d_o = sc_q_i;
  end

  assign din_ready_o = din_ready_q;
  assign sc_en_o     = sc_en_q;
  assign sc_clr_o    = sc_clr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sc_chain_loader.sv
// Bench for sc_chain_loader: two instances (64/8 and 20/8) with behavioural
// chain models. A stimulus process pushes the expected outcome of each load
// into a scoreboard; a monitor pops it when done pulses.
module tb_sc_chain_loader;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, din_valid = 1'b0, inj = 1'b0;
  logic [7:0] din = '0;
  bit         sel = 1'b0;

  logic rdy0, d0, en0, clr0, q0, busy0, done0, err0;
  logic rdy1, d1, en1, clr1, q1, busy1, done1, err1;
  logic [63:0] ch0 = '0;
  logic [19:0] ch1 = '0;

  always #5 clk = ~clk;

  sc_chain_loader #(.CHAIN_LEN(64), .WORD_W(8)) u0 (
    .clk(clk), .reset(reset), .start_i(start & ~sel), .din_i(din),
    .din_valid_i(din_valid & ~sel), .din_ready_o(rdy0), .sc_d_o(d0),
    .sc_en_o(en0), .sc_clr_o(clr0), .sc_q_i(q0), .busy_o(busy0),
    .done_o(done0), .err_o(err0));

  sc_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u1 (
    .clk(clk), .reset(reset), .start_i(start & sel), .din_i(din),
    .din_valid_i(din_valid & sel), .din_ready_o(rdy1), .sc_d_o(d1),
    .sc_en_o(en1), .sc_clr_o(clr1), .sc_q_i(q1), .busy_o(busy1),
    .done_o(done1), .err_o(err1));

  // Chain models: index 0 is the tail, new bits enter at the head.
  assign q0 = ch0[0] ^ (inj & ~sel);
  assign q1 = ch1[0] ^ (inj & sel);
  always @(posedge clk) begin
    if (clr0) ch0 <= '0; else if (en0) ch0 <= {d0, ch0[63:1]};
    if (clr1) ch1 <= '0; else if (en1) ch1 <= {d1, ch1[19:1]};
  end

  logic m_rdy, m_d, m_en, m_clr, m_busy, m_done, m_err;
  logic [63:0] m_chain;
  assign m_rdy   = sel ? rdy1  : rdy0;
  assign m_d     = sel ? d1    : d0;
  assign m_en    = sel ? en1   : en0;
  assign m_clr   = sel ? clr1  : clr0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;
  assign m_err   = sel ? err1  : err0;
  assign m_chain = sel ? {44'd0, ch1} : ch0;

  typedef struct {
    logic [63:0] chain;
    logic        err;
    int          en;
    int          hs;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  int en_cnt = 0, hs_cnt = 0, busy_cnt = 0, clr_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Monitor: per-cycle protocol checks plus scoreboard pop on done.
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      en_cnt = 0; hs_cnt = 0; busy_cnt = 0; clr_cnt = 0;
    end else begin
      if (m_en) en_cnt++;
      if (m_rdy && din_valid) hs_cnt++;
      if (m_busy) busy_cnt++;
      if (m_busy && m_clr) clr_cnt++;
      if (!m_busy) begin
        chk("idle_ready", m_rdy, 0);
        chk("idle_en", m_en, 0);
      end
      if (m_rdy) chk("fetch_en", m_en, 0);
      if (m_done) begin
        if (sb.size() == 0) fail_now("unexpected_done");
        else begin
          e = sb.pop_front();
          chk("err", m_err, e.err);
          chk("chain", m_chain, e.chain);
          chk("en_cycles", en_cnt, e.en);
          chk("words_fetched", hs_cnt, e.hs);
          chk("latency", busy_cnt, e.lat);
          chk("clear_cycles", clr_cnt, 1);
        end
        en_cnt = 0; hs_cnt = 0; busy_cnt = 0; clr_cnt = 0;
      end
    end
  end

  // Reference: the first n bits of the word stream, LSB first; bit k lands at
  // chain position k (first bit at the tail).
  function automatic logic [63:0] ref_chain(input int n, input logic [7:0] w[$]);
    logic [63:0] r = '0;
    int idx = 0;
    foreach (w[i]) for (int b = 0; b < 8; b++)
      if (idx < n) begin r[idx] = w[i][b]; idx++; end
    return r;
  endfunction

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", m_busy, 1);
    chk("start_clr", m_clr, 1);
    chk("start_err_cleared", m_err, 0);
  endtask

  // Offers each word; s idle-valid cycles are inserted after ready rises.
  task automatic drive(input logic [7:0] w[$], input int s, input int need);
    int t;
    logic rd;
    for (int i = 0; i < w.size(); i++) begin
      din = w[i];
      if (s > 0) begin
        din_valid = 1'b0;
        t = 0;
        while (!m_rdy) begin
          @(posedge clk); #1;
          t++;
          if (reset) begin din_valid = 1'b0; return; end
          if (t > 300) begin if (i < need) fail_now("fetch_wait"); din_valid = 1'b0; return; end
        end
        for (int k = 0; k < s; k++) begin
          chk("stall_ready", m_rdy, 1);
          chk("stall_en", m_en, 0);
          @(posedge clk); #1;
        end
      end
      din_valid = 1'b1;
      t = 0;
      do begin
        rd = m_rdy;
        @(posedge clk); #1;
        t++;
        if (reset) begin din_valid = 1'b0; return; end
        if (t > 300) begin if (i < need) fail_now("handshake"); din_valid = 1'b0; return; end
      end while (!rd);
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_en(input int target, input string nm);
    int t = 0;
    while (en_cnt != target) begin
      @(posedge clk); #1;
      t++;
      if (t > 3000) begin fail_now(nm); return; end
    end
  endtask

  task automatic inject(input int target);
    wait_en(target, "inject_wait");
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
  endtask

  task automatic poke_start();
    wait_en(10, "poke_wait");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input bit s_sel, input logic [7:0] w[$], input int s,
                          input int fj, input bit poke);
    exp_t x;
    int n, need, lat, rem, b, t;
    n = s_sel ? 20 : 64;
    need = (n + 7) / 8;
    lat = 1; rem = n;
    for (int i = 0; i < need; i++) begin
      b = (rem < 8) ? rem : 8;
      lat += 1 + s + b;
      rem -= b;
    end
    lat += n + 1;
    x.chain = ref_chain(n, w);
    if (fj >= 0) x.chain = x.chain ^ (64'd1 << fj);
    x.err = (fj >= 0);
    x.en  = 2 * n;
    x.hs  = need;
    x.lat = lat;
    sel = s_sel;
    sb.push_back(x);
    do_start();
    fork
      drive(w, s, need);
      if (fj >= 0) inject(n + fj);
      if (poke) poke_start();
    join
    t = 0;
    while (sb.size() > 0 && t < 3000) begin @(posedge clk); #1; t++; end
    if (sb.size() > 0) begin fail_now("done_wait"); sb.delete(); end
  endtask

  function automatic void rand_words(output logic [7:0] w[$]);
    w = {};
    for (int i = 0; i < 8; i++) w.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0] w[$];
    #23;
    chk("rst_clr", clr0, 1);
    chk("rst_en", en0, 0);
    chk("rst_d", d0, 0);
    chk("rst_ready", rdy0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    w = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(1'b0, w, 0, -1, 1'b0);
    chk("contents_01_08", ch0, 64'h0807060504030201);
    run_load(1'b0, w, 5, -1, 1'b0);

    // Short chain: an extra word is offered but must never be fetched; it
    // also stays valid through IDLE.
    w = {8'hFF, 8'hFF, 8'hAB, 8'h55};
    run_load(1'b1, w, 0, -1, 1'b0);
    chk("contents_short", ch1, 20'hBFFFF);

    rand_words(w);
    run_load(1'b0, w, 0, int'($urandom_range(0, 63)), 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("err_held", m_err, 1);
    rand_words(w);
    run_load(1'b0, w, 0, -1, 1'b1);

    // Abort mid-shift after 30 bits.
    sel = 1'b0;
    w = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_start();
    fork
      drive(w, 0, 8);
      begin
        wait_en(30, "abort_wait");
        #2 reset = 1'b1;
        #1;
        chk("abort_clr", clr0, 1);
        chk("abort_en", en0, 0);
        chk("abort_d", d0, 0);
        chk("abort_ready", rdy0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
      end
    join
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    rand_words(w);
    run_load(1'b0, w, 0, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rand_words(w);
      run_load(1'($urandom_range(0, 1)), w, int'($urandom_range(0, 2)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19)) : -1,
               1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
